// File: rtl/key_judge_player.sv
// Judges player key presses against the LFSR target key and drives the score counter.
// Every output is registered so that correct_pulse is glitch-free when used as a clock.
module key_judge_player #(
   parameter int         LOCKOUT_CYCLES = 25_000_000,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_in,
   input  logic       game_ended,
   output logic [1:0] target_key,
   output logic       correct_pulse,
   output logic       wrong_pulse,
   output logic       counter_resetn,
   output logic       busy
);

   localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   typedef enum logic [2:0] {S_INIT0, S_INIT1, S_WAIT, S_LOCK, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [3:0]      sync1, sync2, prev;
   logic [3:0]      press_vec;
   logic [3:0]      target_onehot;
   logic            hit;
   logic [7:0]      lfsr, lfsr_nxt;
   logic [CW-1:0]   lock_cnt, lock_cnt_nxt;
   logic            lock_last;
   logic            correct_nxt, wrong_nxt, busy_nxt, resetn_nxt;

   assign press_vec     = sync2 & ~prev;
   assign target_onehot = 4'b0001 << target_key;
   assign hit           = (press_vec == target_onehot);
   assign lock_last     = (lock_cnt == CW'(LOCKOUT_CYCLES - 1));

   // State register, including the registered outputs and datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_INIT0;
         sync1          <= '0;
         sync2          <= '0;
         prev           <= '0;
         lfsr           <= LFSR_SEED;
         target_key     <= LFSR_SEED[1:0];
         lock_cnt       <= '0;
         correct_pulse  <= 1'b0;
         wrong_pulse    <= 1'b0;
         counter_resetn <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state          <= state_nxt;
         sync1          <= key_in;
         sync2          <= sync1;
         prev           <= sync2;
         lfsr           <= lfsr_nxt;
         target_key     <= lfsr_nxt[1:0];
         lock_cnt       <= lock_cnt_nxt;
         correct_pulse  <= correct_nxt;
         wrong_pulse    <= wrong_nxt;
         counter_resetn <= resetn_nxt;
         busy           <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT0: state_nxt = S_INIT1;
         S_INIT1: state_nxt = S_WAIT;
         S_WAIT: begin
            if (game_ended)
               state_nxt = S_DONE;
            else if ((press_vec != 4'b0000) && !hit)
               state_nxt = S_LOCK;
         end
         S_LOCK: begin
            if (game_ended)
               state_nxt = S_DONE;
            else if (lock_last)
               state_nxt = S_WAIT;
         end
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_INIT0;
      endcase
   end

   // The INIT1 pulse is what makes the counter sample its reset low and load its start value.
   always_comb begin
      correct_nxt  = 1'b0;
      wrong_nxt    = 1'b0;
      lfsr_nxt     = lfsr;
      lock_cnt_nxt = '0;
      case (state)
         S_INIT0: correct_nxt = 1'b1;
         S_WAIT: begin
            if (!game_ended && (press_vec != 4'b0000)) begin
               if (hit) begin
                  correct_nxt = 1'b1;
                  lfsr_nxt    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
               end else begin
                  wrong_nxt = 1'b1;
               end
            end
         end
         S_LOCK:  lock_cnt_nxt = lock_cnt + CW'(1);
         default: ;
      endcase
      busy_nxt   = (state_nxt == S_LOCK);
      resetn_nxt = (state_nxt != S_INIT0) && (state_nxt != S_INIT1);
   end

endmodule

// File: tb/tb_key_judge_player.sv
// Directed bench for key_judge_player with a short lockout.
module tb_key_judge_player;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_in;
   logic       game_ended;
   logic [1:0] target_key;
   logic       correct_pulse, wrong_pulse, counter_resetn, busy;

   int pass_cnt = 0;
   int tot_cnt  = 0;
   int c_cnt = 0, w_cnt = 0, busy_cyc = 0, overlap = 0;

   key_judge_player #(.LOCKOUT_CYCLES(4), .LFSR_SEED(8'hA5)) dut (
      .clk(clk), .reset(reset), .key_in(key_in), .game_ended(game_ended),
      .target_key(target_key), .correct_pulse(correct_pulse), .wrong_pulse(wrong_pulse),
      .counter_resetn(counter_resetn), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (correct_pulse) c_cnt++;
      if (wrong_pulse) w_cnt++;
      if (busy) busy_cyc++;
      if (correct_pulse && wrong_pulse) overlap++;
   end

   typedef struct {
      logic [3:0] key;
      int         exp_c;
      int         exp_w;
      logic [1:0] exp_tgt;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic init_seq(input string tag);
      check({tag, " init0 resetn"}, int'(counter_resetn), 0);
      check({tag, " init0 pulse"}, int'(correct_pulse), 0);
      check({tag, " init0 target"}, int'(target_key), 1);
      check({tag, " init0 busy"}, int'(busy), 0);
      tick();
      check({tag, " init1 resetn"}, int'(counter_resetn), 0);
      check({tag, " init1 pulse"}, int'(correct_pulse), 1);
      tick();
      check({tag, " wait resetn"}, int'(counter_resetn), 1);
      check({tag, " wait pulse"}, int'(correct_pulse), 0);
   endtask

   initial begin
      int c0, w0, b0;
      // Target sequence from seed A5: 4A(10) 95(01) 2A(10) 54(00) A9(01) 53(11)
      vecs[0] = '{key: 4'b0001, exp_c: 0, exp_w: 1, exp_tgt: 2'b10};
      vecs[1] = '{key: 4'b0100, exp_c: 1, exp_w: 0, exp_tgt: 2'b01};
      vecs[2] = '{key: 4'b0011, exp_c: 0, exp_w: 1, exp_tgt: 2'b01};
      vecs[3] = '{key: 4'b0010, exp_c: 1, exp_w: 0, exp_tgt: 2'b10};
      vecs[4] = '{key: 4'b0100, exp_c: 1, exp_w: 0, exp_tgt: 2'b00};
      vecs[5] = '{key: 4'b0001, exp_c: 1, exp_w: 0, exp_tgt: 2'b01};
      vecs[6] = '{key: 4'b1000, exp_c: 0, exp_w: 1, exp_tgt: 2'b01};
      vecs[7] = '{key: 4'b0110, exp_c: 0, exp_w: 1, exp_tgt: 2'b01};

      reset = 1'b1; key_in = 4'b0000; game_ended = 1'b0;
      tick(); tick();
      check("rst wrong", int'(wrong_pulse), 0);
      check("rst pulse", int'(correct_pulse), 0);
      reset = 1'b0;
      init_seq("boot");

      // Held correct key: one pulse, three cycles after the input edge
      c0 = c_cnt;
      key_in = 4'b0010;
      tick(); check("lat c1", int'(correct_pulse), 0);
      tick(); check("lat c2", int'(correct_pulse), 0);
      tick(); check("lat c3", int'(correct_pulse), 1);
      tick(); check("lat c4", int'(correct_pulse), 0);
      check("lat target", int'(target_key), 2);
      repeat (7) tick();
      key_in = 4'b0000;
      repeat (3) tick();
      check("held one pulse", c_cnt - c0, 1);

      for (int i = 0; i < 8; i++) begin
         c0 = c_cnt; w0 = w_cnt;
         key_in = vecs[i].key;
         repeat (3) tick();
         key_in = 4'b0000;
         repeat (8) tick();
         check($sformatf("vec%0d correct", i), c_cnt - c0, vecs[i].exp_c);
         check($sformatf("vec%0d wrong", i), w_cnt - w0, vecs[i].exp_w);
         check($sformatf("vec%0d target", i), int'(target_key), int'(vecs[i].exp_tgt));
      end

      // Lockout: exactly 4 busy cycles, correct press inside it is discarded
      c0 = c_cnt; w0 = w_cnt; b0 = busy_cyc;
      key_in = 4'b1000;
      tick(); tick(); tick();
      check("lock wrong", int'(wrong_pulse), 1);
      check("lock busy", int'(busy), 1);
      key_in = 4'b0010;
      repeat (6) tick();
      check("lock busy dropped", int'(busy), 0);
      key_in = 4'b0000;
      repeat (3) tick();
      check("lock busy cycles", busy_cyc - b0, 4);
      check("lock no correct", c_cnt - c0, 0);
      check("lock one wrong", w_cnt - w0, 1);
      key_in = 4'b0010;
      repeat (3) tick();
      key_in = 4'b0000;
      repeat (3) tick();
      check("after lock correct", c_cnt - c0, 1);
      check("after lock target", int'(target_key), 3);

      // game_ended coinciding with a correct edge wins; DONE is sticky
      c0 = c_cnt; w0 = w_cnt;
      key_in = 4'b1000;
      tick(); tick();
      game_ended = 1'b1;
      tick();
      check("end no pulse", int'(correct_pulse), 0);
      tick();
      game_ended = 1'b0;
      key_in = 4'b0000;
      repeat (3) tick();
      key_in = 4'b1000; repeat (3) tick(); key_in = 4'b0000; repeat (3) tick();
      key_in = 4'b0001; repeat (3) tick(); key_in = 4'b0000; repeat (8) tick();
      check("done correct", c_cnt - c0, 0);
      check("done wrong", w_cnt - w0, 0);
      check("done busy", int'(busy), 0);
      check("done target frozen", int'(target_key), 3);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      init_seq("rerun");

      // Reset arriving while correct_pulse is high
      key_in = 4'b0010;
      tick(); tick(); tick();
      check("mid pulse high", int'(correct_pulse), 1);
      reset = 1'b1;
      tick();
      check("mid pulse cleared", int'(correct_pulse), 0);
      check("mid resetn low", int'(counter_resetn), 0);
      check("mid target seed", int'(target_key), 1);
      reset = 1'b0;
      key_in = 4'b0000;
      init_seq("mid");

      check("pulse overlap", overlap, 0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
